// File: rtl/restrict_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | restrict_add : 5-stage pipelined adder tree summing four two's-complement   |
// |                lanes, wrapping modulo 2^NUM_WIDTH.      Revision 1.0        |
// +----------------------------------------------------------------------------+
module restrict_add #(
   parameter int GROUP_NB  = 4,
   parameter int NUM_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          up_valid,
   input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
   output logic                          dn_valid,
   output logic [NUM_WIDTH-1:0]          dn_data
);

   localparam int VALID_DEPTH = 5;

   generate
      if (GROUP_NB != 4) begin : g_bad_group_nb
         $fatal(1, "group number must be set as '4'");
      end
   endgenerate

   logic [NUM_WIDTH*GROUP_NB-1:0] in_data_q, in_data_d;
   logic [VALID_DEPTH-1:0]        valid_q, valid_d;
   logic [NUM_WIDTH-1:0]          lane [4];

   // Two's-complement wrap is bit-identical for signed and unsigned adds,
   // so plain truncating adders give the signed modular result.
   (* use_dsp48 = "no" *) logic [NUM_WIDTH-1:0] sum01_q, sum23_q;
   logic [NUM_WIDTH-1:0]                        sum01_d, sum23_d;
   logic [NUM_WIDTH-1:0]                        ret01_q, ret23_q, ret01_d, ret23_d;
   (* use_dsp48 = "no" *) logic [NUM_WIDTH-1:0] total_q;
   logic [NUM_WIDTH-1:0]                        total_d;
   logic [NUM_WIDTH-1:0]                        out_q, out_d;

   generate
      for (genvar k = 0; k < 4; k++) begin : g_lane
         assign lane[k] = in_data_q[k*NUM_WIDTH +: NUM_WIDTH];
      end
   endgenerate

   always_comb begin
      in_data_d = up_data;
      valid_d   = {valid_q[VALID_DEPTH-2:0], up_valid};
      sum01_d   = lane[0] + lane[1];
      sum23_d   = lane[2] + lane[3];
      ret01_d   = sum01_q;
      ret23_d   = sum23_q;
      total_d   = ret01_q + ret23_q;
      out_d     = total_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_data_q <= '0;
         valid_q   <= '0;
         sum01_q   <= '0;
         sum23_q   <= '0;
         ret01_q   <= '0;
         ret23_q   <= '0;
         total_q   <= '0;
         out_q     <= '0;
      end else begin
         in_data_q <= in_data_d;
         valid_q   <= valid_d;
         sum01_q   <= sum01_d;
         sum23_q   <= sum23_d;
         ret01_q   <= ret01_d;
         ret23_q   <= ret23_d;
         total_q   <= total_d;
         out_q     <= out_d;
      end
   end

   assign dn_data  = out_q;
   assign dn_valid = valid_q[VALID_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_restrict_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_restrict_add : scoreboard bench for the restrict_add adder tree.         |
// |                                                        Revision 1.0        |
// +----------------------------------------------------------------------------+
module tb_restrict_add;

   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          up_valid;
   logic [4*NW-1:0] up_data;
   logic          dn_valid;
   logic [NW-1:0] dn_data;

   int checks   = 0;
   int failures = 0;

   logic [NW:0] exp_q [$];

   restrict_add #(.GROUP_NB(4), .NUM_WIDTH(NW)) dut (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_valid (dn_valid),
      .dn_data  (dn_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NW-1:0] lane_sum(input logic [4*NW-1:0] d);
      logic [NW-1:0] s;
      s = d[0 +: NW] + d[NW +: NW] + d[2*NW +: NW] + d[3*NW +: NW];
      return s;
   endfunction

   function automatic logic [4*NW-1:0] pack4(input logic [NW-1:0] l0, input logic [NW-1:0] l1,
                                             input logic [NW-1:0] l2, input logic [NW-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // One clock: drive inputs, take the edge, update the scoreboard, compare.
   task automatic cycle(input logic r, input logic v, input logic [4*NW-1:0] d);
      logic [NW:0] e;
      rst      = r;
      up_valid = v;
      up_data  = d;
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         repeat (4) exp_q.push_back('0);
         e = '0;
      end else begin
         if (exp_q.size() == 0) e = '0;
         else e = exp_q.pop_front();
         exp_q.push_back({v, lane_sum(d)});
      end
      check("dn_valid", {31'd0, dn_valid}, {31'd0, e[NW]});
      check("dn_data", {16'd0, dn_data}, {16'd0, e[NW-1:0]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
   endtask

   function automatic logic [4*NW-1:0] rand_data();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      rst = 1'b1; up_valid = 1'b0; up_data = '0;

      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, pack4(16'd9, 16'd9, 16'd9, 16'd9));
      idle(6);

      // basic sum 1+2+3+4
      cycle(1'b0, 1'b1, pack4(16'd1, 16'd2, 16'd3, 16'd4));
      idle(7);

      // signed mix -> -95
      cycle(1'b0, 1'b1, pack4(-16'sd5, 16'sd7, -16'sd100, 16'sd3));
      idle(6);

      // wrap-around cases
      cycle(1'b0, 1'b1, pack4(16'h7FFF, 16'h0001, 16'h0000, 16'h0000));
      cycle(1'b0, 1'b1, pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
      cycle(1'b0, 1'b0, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
      idle(6);

      // back-to-back streaming with random valid
      for (int i = 0; i < 1000; i++) cycle(1'b0, 1'($urandom_range(0, 1)), rand_data());

      // reset mid-stream with sums in flight
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rand_data() | 64'h1);
      cycle(1'b1, 1'b1, rand_data());
      cycle(1'b1, 1'b1, rand_data());
      idle(6);

      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, rand_data());
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
